// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- valid/ready pipeline register between memory and writeback.
//
// Holds {data, alu, ctrl, instr} entries. Entries are accepted on in_valid &
// in_ready and presented downstream until out_valid & out_ready.
//
// Build option: define PIPE_STAGE_REG_SKID_EN to add a one-entry skid register
// behind the main register. In that build in_ready is registered ("skid empty")
// and two entries can be held. Without the macro only the main register exists
// and in_ready = !out_valid | out_ready (combinational).
//
// Ports:
//   clk, reset (async, active-low), flush (sync kill of all held entries)
//   in_valid/in_ready, in_data, in_alu, in_ctrl, in_instr   -- upstream side
//   out_valid/out_ready, out_data, out_alu, out_ctrl, out_instr -- downstream side
// out_ctrl is forced to zero while out_valid=0 so bubbles never write the RF;
// the other payload outputs keep their last values.
module pipe_stage_reg #(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned CTRL_W  = 23,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [0:DATA_W-1]  in_data,
  input  logic [0:DATA_W-1]  in_alu,
  input  logic [0:CTRL_W-1]  in_ctrl,
  input  logic [0:INSTR_W-1] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [0:DATA_W-1]  out_data,
  output logic [0:DATA_W-1]  out_alu,
  output logic [0:CTRL_W-1]  out_ctrl,
  output logic [0:INSTR_W-1] out_instr
);

  logic               main_v_q,     main_v_d;
  logic [0:DATA_W-1]  main_data_q,  main_data_d;
  logic [0:DATA_W-1]  main_alu_q,   main_alu_d;
  logic [0:CTRL_W-1]  main_ctrl_q,  main_ctrl_d;
  logic [0:INSTR_W-1] main_instr_q, main_instr_d;

  logic accept;
  logic xfer;

  assign accept = in_valid & in_ready;
  assign xfer   = main_v_q & out_ready;

`ifdef PIPE_STAGE_REG_SKID_EN

  logic               skid_v_q,     skid_v_d;
  logic [0:DATA_W-1]  skid_data_q,  skid_data_d;
  logic [0:DATA_W-1]  skid_alu_q,   skid_alu_d;
  logic [0:CTRL_W-1]  skid_ctrl_q,  skid_ctrl_d;
  logic [0:INSTR_W-1] skid_instr_q, skid_instr_d;
  logic               rdy_q,        rdy_d;

  // Gated with reset so in_ready reads 0 throughout reset; the flop itself
  // comes out of reset at 1 so the first post-reset cycle can accept.
  assign in_ready = rdy_q & reset;

  always_comb begin
    main_v_d     = main_v_q;
    main_data_d  = main_data_q;
    main_alu_d   = main_alu_q;
    main_ctrl_d  = main_ctrl_q;
    main_instr_d = main_instr_q;
    skid_v_d     = skid_v_q;
    skid_data_d  = skid_data_q;
    skid_alu_d   = skid_alu_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_instr_d = skid_instr_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || xfer) begin
      // Main slot is free this edge: the older skid entry goes first to keep
      // order. A full skid implies in_ready=0, so no accept can collide here.
      if (skid_v_q) begin
        main_v_d     = 1'b1;
        main_data_d  = skid_data_q;
        main_alu_d   = skid_alu_q;
        main_ctrl_d  = skid_ctrl_q;
        main_instr_d = skid_instr_q;
        skid_v_d     = 1'b0;
      end else if (accept) begin
        main_v_d     = 1'b1;
        main_data_d  = in_data;
        main_alu_d   = in_alu;
        main_ctrl_d  = in_ctrl;
        main_instr_d = in_instr;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (accept) begin
      // Main is stalled: park the new entry in the skid slot.
      skid_v_d     = 1'b1;
      skid_data_d  = in_data;
      skid_alu_d   = in_alu;
      skid_ctrl_d  = in_ctrl;
      skid_instr_d = in_instr;
    end
    rdy_d = ~skid_v_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_v_q     <= 1'b0;
      skid_data_q  <= '0;
      skid_alu_q   <= '0;
      skid_ctrl_q  <= '0;
      skid_instr_q <= '0;
      rdy_q        <= 1'b1;
    end else begin
      skid_v_q     <= skid_v_d;
      skid_data_q  <= skid_data_d;
      skid_alu_q   <= skid_alu_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_instr_q <= skid_instr_d;
      rdy_q        <= rdy_d;
    end
  end

`else

  assign in_ready = reset & (~main_v_q | out_ready);

  always_comb begin
    main_v_d     = main_v_q;
    main_data_d  = main_data_q;
    main_alu_d   = main_alu_q;
    main_ctrl_d  = main_ctrl_q;
    main_instr_d = main_instr_q;
    if (flush) begin
      main_v_d = 1'b0;
    end else if (accept) begin
      main_v_d     = 1'b1;
      main_data_d  = in_data;
      main_alu_d   = in_alu;
      main_ctrl_d  = in_ctrl;
      main_instr_d = in_instr;
    end else if (xfer) begin
      main_v_d = 1'b0;
    end
  end

`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_v_q     <= 1'b0;
      main_data_q  <= '0;
      main_alu_q   <= '0;
      main_ctrl_q  <= '0;
      main_instr_q <= '0;
    end else begin
      main_v_q     <= main_v_d;
      main_data_q  <= main_data_d;
      main_alu_q   <= main_alu_d;
      main_ctrl_q  <= main_ctrl_d;
      main_instr_q <= main_instr_d;
    end
  end

  assign out_valid = main_v_q;
  assign out_data  = main_data_q;
  assign out_alu   = main_alu_q;
  assign out_instr = main_instr_q;
  assign out_ctrl  = main_v_q ? main_ctrl_q : '0;

endmodule
